// File: rtl/cache_axi_bridge_if.sv
// AXI3 master bus used by cache_axi_bridge: 4-bit IDs, 32-bit data.
//   master modport: bridge side (drives AR/AW/W, rready, bready)
//   slave modport : memory side (drives arready/awready/wready, R and B channels)
interface cache_axi_bridge_if;
  // Read address channel
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [3:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  // Read data channel
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  // Write address channel
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [3:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic [1:0]  awlock;
  logic [3:0]  awcache;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  // Write data channel
  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  // Write response channel
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/cache_axi_bridge.sv
// Cache-to-AXI3 bridge.
//   NUM_RD cache read ports (port i issues with ARID=i) and one write-back port (AWID=WID=NUM_RD).
//   Read ports: rd_req/rd_type/rd_addr in, rd_rdy out; R beats routed back on ret_valid/ret_last
//   by RID, with shared ret_data. Write port: wr_req/wr_type/wr_addr/wr_wstrb/wr_data in, wr_rdy out.
//   axi: AXI3 master. Reads hitting the line of an in-flight write are held until its B arrives.
//   aclk / aresetn: clock and synchronous active-low reset.
module cache_axi_bridge #(
  parameter int unsigned NUM_RD     = 2,
  parameter int unsigned LINE_WORDS = 4
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic [NUM_RD-1:0]        rd_req,
  input  logic [3*NUM_RD-1:0]      rd_type,
  input  logic [32*NUM_RD-1:0]     rd_addr,
  output logic [NUM_RD-1:0]        rd_rdy,
  output logic [NUM_RD-1:0]        ret_valid,
  output logic [NUM_RD-1:0]        ret_last,
  output logic [31:0]              ret_data,
  input  logic                     wr_req,
  input  logic [2:0]               wr_type,
  input  logic [31:0]              wr_addr,
  input  logic [3:0]               wr_wstrb,
  input  logic [32*LINE_WORDS-1:0] wr_data,
  output logic                     wr_rdy,
  cache_axi_bridge_if.master       axi
);

  localparam int unsigned OFS  = $clog2(LINE_WORDS * 4);
  localparam int unsigned IdxW = (NUM_RD > 1) ? $clog2(NUM_RD) : 1;
  localparam int unsigned CntW = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;

  localparam logic [31:0] LineMask = ~((32'd1 << OFS) - 32'd1);
  localparam logic [3:0]  LineLen  = 4'(LINE_WORDS - 1);
  localparam logic [2:0]  TypeLine = 3'd4;
  localparam logic [3:0]  WrId     = 4'(NUM_RD);

  typedef enum logic [1:0] {WIdle, WXfer, WResp} wstate_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [NUM_RD-1:0] pend_q, pend_d;
  logic [NUM_RD-1:0] iss_q, iss_d;
  logic [31:0]       raddr_q [NUM_RD];
  logic [31:0]       raddr_d [NUM_RD];
  logic [2:0]        rtype_q [NUM_RD];
  logic [2:0]        rtype_d [NUM_RD];

  logic              arvalid_q, arvalid_d;
  logic [3:0]        arid_q, arid_d;
  logic [31:0]       araddr_q, araddr_d;
  logic [3:0]        arlen_q, arlen_d;
  logic [2:0]        arsize_q, arsize_d;
  logic [IdxW-1:0]   last_q, last_d;

  wstate_e           wstate_q, wstate_d;
  logic [31:0]       waddr_q, waddr_d;
  logic [2:0]        wtype_q, wtype_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic [31:0]       wbuf_q [LINE_WORDS];
  logic [31:0]       wbuf_d [LINE_WORDS];
  logic [CntW-1:0]   wcnt_q, wcnt_d;
  logic              aw_done_q, aw_done_d;
  logic              w_done_q, w_done_d;

  // ---------------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------------
  logic              w_line;
  logic [3:0]        w_len;
  logic              w_busy;
  logic              wr_acc;
  logic [NUM_RD-1:0] r_done;
  logic [NUM_RD-1:0] ar_blk;
  logic [NUM_RD-1:0] ar_cand;
  logic              grant_ok;
  logic [IdxW-1:0]   grant_idx;

  assign wr_acc = wr_req && wr_rdy;
  // The write stops guarding its line in the cycle its B response is taken, so a held read's
  // AR can go out on the following cycle.
  assign w_busy = (wstate_q == WXfer) || ((wstate_q == WResp) && !axi.bvalid);

  always_comb begin
    ret_valid = '0;
    ret_last  = '0;
    r_done    = '0;
    ar_blk    = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      // RIDs outside the read-port range match nothing and are dropped.
      ret_valid[i] = aresetn && axi.rvalid && (axi.rid == 4'(i));
      ret_last[i]  = ret_valid[i] && axi.rlast;
      r_done[i]    = ret_last[i];
      ar_blk[i]    = (w_busy && ((raddr_q[i] & LineMask) == (waddr_q & LineMask))) ||
                     (wr_acc && ((raddr_q[i] & LineMask) == (wr_addr & LineMask)));
    end
  end

  assign ret_data   = axi.rdata;
  assign rd_rdy     = aresetn ? ~pend_q : '0;
  assign axi.rready = aresetn;

  // ---------------------------------------------------------------------------
  // Read ports and AR arbitration
  // ---------------------------------------------------------------------------
  always_comb begin
    pend_d    = pend_q;
    iss_d     = iss_q;
    raddr_d   = raddr_q;
    rtype_d   = rtype_q;
    arvalid_d = arvalid_q;
    arid_d    = arid_q;
    araddr_d  = araddr_q;
    arlen_d   = arlen_q;
    arsize_d  = arsize_q;
    last_d    = last_q;
    grant_ok  = 1'b0;
    grant_idx = '0;

    for (int i = 0; i < NUM_RD; i++) begin
      if (r_done[i]) begin
        pend_d[i] = 1'b0;
        iss_d[i]  = 1'b0;
      end
      if (rd_req[i] && rd_rdy[i]) begin
        pend_d[i]  = 1'b1;
        iss_d[i]   = 1'b0;
        raddr_d[i] = rd_addr[32*i +: 32];
        rtype_d[i] = rd_type[3*i +: 3];
      end
    end

    ar_cand = pend_q & ~iss_q & ~ar_blk;

    // Round-robin: first candidate above the last grant, else the lowest candidate.
    for (int i = 0; i < NUM_RD; i++) begin
      if (!grant_ok && ar_cand[i] && (i > int'(last_q))) begin
        grant_ok  = 1'b1;
        grant_idx = IdxW'(i);
      end
    end
    for (int i = 0; i < NUM_RD; i++) begin
      if (!grant_ok && ar_cand[i]) begin
        grant_ok  = 1'b1;
        grant_idx = IdxW'(i);
      end
    end

    if (arvalid_q) begin
      if (axi.arready) begin
        arvalid_d = 1'b0;
      end
    end else if (grant_ok) begin
      arvalid_d        = 1'b1;
      arid_d           = 4'(grant_idx);
      last_d           = grant_idx;
      iss_d[grant_idx] = 1'b1;
      if (rtype_q[grant_idx] == TypeLine) begin
        araddr_d = raddr_q[grant_idx] & LineMask;
        arlen_d  = LineLen;
        arsize_d = 3'd2;
      end else begin
        araddr_d = raddr_q[grant_idx];
        arlen_d  = 4'd0;
        arsize_d = {1'b0, rtype_q[grant_idx][1:0]};
      end
    end
  end

  assign axi.arvalid = arvalid_q;
  assign axi.arid    = arid_q;
  assign axi.araddr  = araddr_q;
  assign axi.arlen   = arlen_q;
  assign axi.arsize  = arsize_q;
  assign axi.arburst = 2'b01;
  assign axi.arlock  = 2'b00;
  assign axi.arcache = 4'd0;
  assign axi.arprot  = 3'd0;

  // ---------------------------------------------------------------------------
  // Write FSM
  // ---------------------------------------------------------------------------
  assign w_line = (wtype_q == TypeLine);
  assign w_len  = w_line ? LineLen : 4'd0;

  assign wr_rdy      = aresetn && (wstate_q == WIdle);
  assign axi.awvalid = (wstate_q == WXfer) && !aw_done_q;
  assign axi.awid    = WrId;
  assign axi.awaddr  = w_line ? (waddr_q & LineMask) : waddr_q;
  assign axi.awlen   = w_len;
  assign axi.awsize  = w_line ? 3'd2 : {1'b0, wtype_q[1:0]};
  assign axi.awburst = 2'b01;
  assign axi.awlock  = 2'b00;
  assign axi.awcache = 4'd0;
  assign axi.awprot  = 3'd0;
  assign axi.wvalid  = (wstate_q == WXfer) && !w_done_q;
  assign axi.wid     = WrId;
  assign axi.wdata   = wbuf_q[wcnt_q];
  assign axi.wstrb   = w_line ? 4'hf : wstrb_q;
  assign axi.wlast   = (4'(wcnt_q) == w_len);
  assign axi.bready  = (wstate_q == WResp);

  always_comb begin
    wstate_d  = wstate_q;
    waddr_d   = waddr_q;
    wtype_d   = wtype_q;
    wstrb_d   = wstrb_q;
    wbuf_d    = wbuf_q;
    wcnt_d    = wcnt_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;

    unique case (wstate_q)
      WIdle: begin
        if (wr_acc) begin
          waddr_d   = wr_addr;
          wtype_d   = wr_type;
          wstrb_d   = wr_wstrb;
          wcnt_d    = '0;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          for (int k = 0; k < LINE_WORDS; k++) begin
            wbuf_d[k] = wr_data[32*k +: 32];
          end
          wstate_d = WXfer;
        end
      end
      WXfer: begin
        // AW and W progress independently; W may finish before AW is accepted.
        if (axi.awvalid && axi.awready) begin
          aw_done_d = 1'b1;
        end
        if (axi.wvalid && axi.wready) begin
          wcnt_d = wcnt_q + 1'b1;
          if (axi.wlast) begin
            w_done_d = 1'b1;
          end
        end
        if (aw_done_d && w_done_d) begin
          wstate_d = WResp;
        end
      end
      WResp: begin
        if (axi.bvalid) begin
          wstate_d = WIdle;
        end
      end
      default: wstate_d = WIdle;
    endcase
  end

  // B response code and ID carry no information the cache needs.
  logic unused_axi;
  assign unused_axi = ^{axi.rresp, axi.bresp, axi.bid};

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      pend_q    <= '0;
      iss_q     <= '0;
      for (int i = 0; i < NUM_RD; i++) begin
        raddr_q[i] <= '0;
        rtype_q[i] <= '0;
      end
      arvalid_q <= 1'b0;
      arid_q    <= '0;
      araddr_q  <= '0;
      arlen_q   <= '0;
      arsize_q  <= '0;
      last_q    <= '0;
      wstate_q  <= WIdle;
      waddr_q   <= '0;
      wtype_q   <= '0;
      wstrb_q   <= '0;
      for (int k = 0; k < LINE_WORDS; k++) begin
        wbuf_q[k] <= '0;
      end
      wcnt_q    <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      pend_q    <= pend_d;
      iss_q     <= iss_d;
      raddr_q   <= raddr_d;
      rtype_q   <= rtype_d;
      arvalid_q <= arvalid_d;
      arid_q    <= arid_d;
      araddr_q  <= araddr_d;
      arlen_q   <= arlen_d;
      arsize_q  <= arsize_d;
      last_q    <= last_d;
      wstate_q  <= wstate_d;
      waddr_q   <= waddr_d;
      wtype_q   <= wtype_d;
      wstrb_q   <= wstrb_d;
      wbuf_q    <= wbuf_d;
      wcnt_q    <= wcnt_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

endmodule
